// File: rtl/input_conditioner.sv
// Reset synchroniser plus per-channel input synchroniser, debouncer,
// press/release edge pulses and long-press detection for active-low inputs.
module input_conditioner #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int RST_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 2048
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic            Test,
  input  logic [N_CH-1:0] nIn,
  output logic            nReset_sync,
  output logic [N_CH-1:0] Level,
  output logic [N_CH-1:0] Press,
  output logic [N_CH-1:0] Release,
  output logic [N_CH-1:0] Long
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [RST_STAGES-1:0] rstChain_r;

  // Reset synchroniser: ones ripple in after nReset releases.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rstChain_r <= {RST_STAGES{1'b0}};
    end else begin
      rstChain_r <= {rstChain_r[RST_STAGES-2:0], 1'b1};
    end
  end

  // Test mode hands the raw reset straight to the downstream core.
  always_comb begin
    if (Test) begin
      nReset_sync = nReset;
    end else begin
      nReset_sync = rstChain_r[RST_STAGES-1];
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : gChan
    logic [SYNC_STAGES-1:0] sync_r;
    logic [DB_W-1:0]        dbCnt_r;
    logic [DB_W-1:0]        dbCntNext_s;
    logic [HOLD_W-1:0]      holdCnt_r;
    logic [HOLD_W-1:0]      holdCntNext_s;
    logic                   level_r;
    logic                   levelNext_s;
    logic                   press_r;
    logic                   release_r;
    logic                   long_r;
    logic                   sample_s;

    assign sample_s = ~sync_r[SYNC_STAGES-1];

    // Debounce next state: toggle only after a full run of differing samples.
    always_comb begin
      levelNext_s = level_r;
      dbCntNext_s = dbCnt_r;
      if (Test) begin
        levelNext_s = sample_s;
        dbCntNext_s = {DB_W{1'b0}};
      end else if (sample_s == level_r) begin
        dbCntNext_s = {DB_W{1'b0}};
      end else if (dbCnt_r == DB_LAST) begin
        levelNext_s = ~level_r;
        dbCntNext_s = {DB_W{1'b0}};
      end else begin
        dbCntNext_s = dbCnt_r + DB_W'(1);
      end
    end

    // Hold counter next state: counts pressed cycles, saturating.
    always_comb begin
      holdCntNext_s = holdCnt_r;
      if (!level_r) begin
        holdCntNext_s = {HOLD_W{1'b0}};
      end else if (holdCnt_r == HOLD_MAX) begin
        holdCntNext_s = holdCnt_r;
      end else begin
        holdCntNext_s = holdCnt_r + HOLD_W'(1);
      end
    end

    // Channel state; pulses derive from next-state so they align with Level.
    always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
        sync_r    <= {SYNC_STAGES{1'b1}};
        dbCnt_r   <= {DB_W{1'b0}};
        holdCnt_r <= {HOLD_W{1'b0}};
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
      end else begin
        sync_r    <= {sync_r[SYNC_STAGES-2:0], nIn[ch]};
        dbCnt_r   <= dbCntNext_s;
        holdCnt_r <= holdCntNext_s;
        level_r   <= levelNext_s;
        press_r   <= levelNext_s & ~level_r;
        release_r <= ~levelNext_s & level_r;
        long_r    <= (holdCntNext_s == HOLD_MAX) && (holdCnt_r != HOLD_MAX);
      end
    end

    assign Level[ch]   = level_r;
    assign Press[ch]   = press_r;
    assign Release[ch] = release_r;
    assign Long[ch]    = long_r;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: stimulus queues expected pulse
// events with their cycle; a monitor pops and compares whenever a pulse shows.
module tb_input_conditioner;

  logic       Clock;
  logic       nReset;
  logic       Test;
  logic [3:0] nIn;
  logic       nReset_sync;
  logic [3:0] Level;
  logic [3:0] Press;
  logic [3:0] Release;
  logic [3:0] Long;

  int checks = 0;
  int failures = 0;
  int edgeCnt = 0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] lvl;
  } evt_t;

  evt_t expQ[$];

  input_conditioner dut (
    .Clock(Clock),
    .nReset(nReset),
    .Test(Test),
    .nIn(nIn),
    .nReset_sync(nReset_sync),
    .Level(Level),
    .Press(Press),
    .Release(Release),
    .Long(Long)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) edgeCnt <= edgeCnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, edgeCnt);
    end
  endtask

  task automatic push(input int cyc, input logic [3:0] p, input logic [3:0] r,
                      input logic [3:0] l, input logic [3:0] lv);
    evt_t e;
    e.cyc = cyc; e.press = p; e.rel = r; e.lng = l; e.lvl = lv;
    expQ.push_back(e);
  endtask

  task automatic waitUntil(input int c);
    while (edgeCnt < c) @(negedge Clock);
  endtask

  // Monitor: every visible pulse must match the next queued event.
  always @(negedge Clock) begin
    if ((Press | Release | Long) != 4'b0000) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse press=%b release=%b long=%b cycle=%0d",
                 Press, Release, Long, edgeCnt);
      end else begin
        evt_t e;
        e = expQ.pop_front();
        check("evt_cycle", edgeCnt, e.cyc);
        check("evt_press", {28'd0, Press}, {28'd0, e.press});
        check("evt_release", {28'd0, Release}, {28'd0, e.rel});
        check("evt_long", {28'd0, Long}, {28'd0, e.lng});
        check("evt_level", {28'd0, Level}, {28'd0, e.lvl});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout cycle=%0d", edgeCnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int r;
    int m;
    Test = 1'b0;
    nIn = 4'hF;
    nReset = 1'b1;
    #1 nReset = 1'b0;

    // Reset state and synchronised reset release
    @(negedge Clock);
    check("rst_nreset_sync", {31'd0, nReset_sync}, 32'd0);
    check("rst_level", {28'd0, Level}, 32'd0);
    check("rst_press", {28'd0, Press}, 32'd0);
    check("rst_release", {28'd0, Release}, 32'd0);
    check("rst_long", {28'd0, Long}, 32'd0);
    nReset = 1'b1;
    @(negedge Clock);
    check("rsync_edge1", {31'd0, nReset_sync}, 32'd0);
    @(negedge Clock);
    check("rsync_edge2", {31'd0, nReset_sync}, 32'd1);
    repeat (20) @(negedge Clock);
    check("idle_level", {28'd0, Level}, 32'd0);

    // Clean press on channel 0 with long press and release
    k = edgeCnt;
    nIn[0] = 1'b0;
    push(k + 18, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    push(k + 18 + 2048, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    waitUntil(k + 17);
    check("ch0_level_before", {31'd0, Level[0]}, 32'd0);
    waitUntil(k + 18);
    check("ch0_level_after", {31'd0, Level[0]}, 32'd1);
    waitUntil(k + 18 + 2048 + 5);
    r = edgeCnt;
    nIn[0] = 1'b1;
    push(r + 18, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    waitUntil(r + 25);

    // Bounce on channel 1: 15 low, 1 high, then low
    k = edgeCnt;
    nIn[1] = 1'b0;
    waitUntil(k + 15);
    nIn[1] = 1'b1;
    waitUntil(k + 16);
    nIn[1] = 1'b0;
    push(k + 34, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    waitUntil(k + 33);
    check("ch1_bounce_level", {31'd0, Level[1]}, 32'd0);
    waitUntil(k + 34 + 60);
    r = edgeCnt;
    nIn[1] = 1'b1;
    push(r + 18, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    waitUntil(r + 25);

    // Short simultaneous press on channels 2 and 3
    k = edgeCnt;
    nIn[3:2] = 2'b00;
    push(k + 18, 4'b1100, 4'b0000, 4'b0000, 4'b1100);
    waitUntil(k + 18 + 100);
    r = edgeCnt;
    nIn[3:2] = 2'b11;
    push(r + 18, 4'b0000, 4'b1100, 4'b0000, 4'b0000);
    waitUntil(r + 40);

    // Test mode: debounce bypass and combinational reset path
    Test = 1'b1;
    repeat (2) @(negedge Clock);
    k = edgeCnt;
    nIn[3] = 1'b0;
    push(k + 3, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    waitUntil(k + 2);
    check("test_level3_before", {31'd0, Level[3]}, 32'd0);
    waitUntil(k + 3);
    check("test_level3_after", {31'd0, Level[3]}, 32'd1);
    #1 nReset = 1'b0;
    #1;
    check("test_rsync_low", {31'd0, nReset_sync}, 32'd0);
    check("test_rst_level3", {31'd0, Level[3]}, 32'd0);
    #1 nReset = 1'b1;
    #1;
    check("test_rsync_high", {31'd0, nReset_sync}, 32'd1);
    m = edgeCnt;
    push(m + 3, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
    waitUntil(m + 10);
    r = edgeCnt;
    nIn[3] = 1'b1;
    push(r + 3, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    waitUntil(r + 6);
    Test = 1'b0;
    @(negedge Clock);
    check("post_test_rsync", {31'd0, nReset_sync}, 32'd1);

    // Async reset mid-hold on channel 0, then re-debounce and long press
    k = edgeCnt;
    nIn[0] = 1'b0;
    push(k + 18, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    waitUntil(k + 68);
    check("hold_level0", {31'd0, Level[0]}, 32'd1);
    #2 nReset = 1'b0;
    #1;
    check("midhold_level0", {31'd0, Level[0]}, 32'd0);
    check("midhold_rsync", {31'd0, nReset_sync}, 32'd0);
    #1 nReset = 1'b1;
    m = edgeCnt;
    push(m + 18, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    push(m + 18 + 2048, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    waitUntil(m + 1);
    check("midhold_rsync_e1", {31'd0, nReset_sync}, 32'd0);
    waitUntil(m + 2);
    check("midhold_rsync_e2", {31'd0, nReset_sync}, 32'd1);
    waitUntil(m + 17);
    check("redebounce_level0", {31'd0, Level[0]}, 32'd0);
    waitUntil(m + 18 + 2048 + 5);
    r = edgeCnt;
    nIn[0] = 1'b1;
    push(r + 18, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    waitUntil(r + 30);

    check("queue_empty", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter N_CH, default 4: number of active-low switch/sensor channels.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth per channel; legal values are 2 or more.
REQ-003 Parameter RST_STAGES, default 2: reset-synchroniser depth; legal values are 2 or more.
REQ-004 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples needed to accept a change; legal values are 1 or more.
REQ-005 Parameter LONG_CYCLES, default 2048: debounced-pressed cycles before a long-press pulse; legal values are 1 or more.
REQ-006 Clock  input  1: single clock; all flops on rising edge.
REQ-007 nReset  input  1: reset, asynchronous, active-low.
REQ-008 Test  input  1: test mode; high = debounce and reset-synchroniser bypass.
REQ-009 nIn  input  N_CH: raw active-low channel inputs, asynchronous to Clock.
REQ-010 nReset_sync  output  1: reset for downstream core; asserts asynchronously, deasserts synchronously.
REQ-011 Level  output  N_CH: debounced state per channel, active-high (1 = pressed).
REQ-012 Press  output  N_CH: one-cycle pulse on the Level 0->1 transition.
REQ-013 Release  output  N_CH: one-cycle pulse on the Level 1->0 transition.
REQ-014 Long  output  N_CH: one-cycle pulse when a press has been held LONG_CYCLES cycles.

Function
REQ-015 Reset sync: chain of RST_STAGES flops; the first D input is tied to 1; all stages are async-cleared by nReset; nReset_sync = last stage.
REQ-016 nReset_sync SHALL go 0 with no clock when nReset falls, and SHALL go 1 on the RST_STAGES-th rising edge after nReset rises.
REQ-017 With Test=1, nReset_sync SHALL equal nReset combinationally.
REQ-018 Per channel, nIn SHALL pass through SYNC_STAGES flops; the synchronised sample s = NOT of the last stage.
REQ-019 Debounce counter: width $clog2(DEBOUNCE_CYCLES+1).
  - Clears when s equals Level.
  - Increments when s differs from Level.
  - When it reaches DEBOUNCE_CYCLES-1 with s still differing, Level toggles and the counter clears on the same edge.
REQ-020 Net effect: Level changes only after DEBOUNCE_CYCLES consecutive differing samples; any agreeing sample restarts the count.
REQ-021 Latency: a clean nIn edge reaches Level after SYNC_STAGES + DEBOUNCE_CYCLES rising edges.
REQ-022 With Test=1, Level SHALL load s on every edge; the debounce counter is held at 0.
REQ-023 Press and Release SHALL be registered, asserted during the cycle in which the new Level is first visible, and never both high at once.
REQ-024 Hold counter: width $clog2(LONG_CYCLES+1).
  - Clears while Level=0.
  - Increments while Level=1.
  - Saturates at LONG_CYCLES.
REQ-025 Long SHALL pulse for exactly one cycle when the hold counter reaches LONG_CYCLES; it pulses at most once per press.
REQ-026 Releasing before LONG_CYCLES SHALL produce no Long pulse.
REQ-027 Channels SHALL be fully independent; simultaneous events on several channels produce simultaneous pulses.

Reset
REQ-028 All flops other than the reset synchroniser SHALL be async-reset by nReset (not by nReset_sync), with these values:
  - Sync stages: 1 (inactive).
  - Level: 0.
  - Counters: 0.
  - Press, Release, Long: 0.
  - nReset_sync: 0.
REQ-029 Reset mid-press SHALL drop Level to 0 with no Release pulse.
  - After reset, a still-held input SHALL be re-debounced.
  - It SHALL then produce a fresh Press pulse, and later a Long pulse.

Verification
REQ-030 Reset release, defaults, Test=0:
  - nReset 0->1 -> nReset_sync high on the 2nd rising edge.
  - All outputs stay 0 while nIn=4'hF.
REQ-031 Clean press, nIn[0] 1->0 held:
  - Level[0]=1 and Press[0] pulse 18 edges later.
  - Long[0] pulse 2048 cycles after Level[0] rose.
  - Release nIn[0] -> Release[0] pulse 18 edges after the input edge.
REQ-032 Bounce, nIn[1] low for 15 cycles, high for 1, then low:
  - Level[1] stays 0 until 16 consecutive low samples have been taken.
  - Exactly one Press[1] pulse.
REQ-033 Short press, held 100 cycles after Level rises:
  - Press and Release pulses occur.
  - No Long pulse.
  - Channels 2 and 3 driven simultaneously -> identical pulse timing on both.
REQ-034 Test=1:
  - nIn[3] low -> Level[3] high 3 edges later.
  - nReset low -> nReset_sync follows combinationally.
  - nReset high -> nReset_sync rises with no clock edge.
REQ-035 Async reset mid-hold:
  - nReset pulsed low between clock edges while Level[0]=1 -> Level[0]=0 immediately, no Release.
  - nIn[0] still held -> new Press[0] 18 edges after reset deasserts.
